// File: rtl/isa_defs_pkg.sv
// isa_defs: shared definitions for the ISA riser blocks.
//   - isa_state_e    : I/O cycle master FSM encoding (3 bits)
//   - DEF_*          : default cycle timing, in clk cycles
//   - ISA_FLOAT_DATA : value a floating (undriven) ISA data bus reads as
//   - max_of         : elaboration-time helper for sizing counters
package isa_defs;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SETUP    = 3'd1,
        ST_STROBE   = 3'd2,
        ST_WAIT_RDY = 3'd3,
        ST_HOLD     = 3'd4,
        ST_RESP     = 3'd5
    } isa_state_e;

    localparam int DEF_SETUP_CYCLES  = 2;
    localparam int DEF_STROBE_CYCLES = 6;
    localparam int DEF_HOLD_CYCLES   = 2;
    localparam int DEF_RDY_TIMEOUT   = 256;

    localparam logic [15:0] ISA_FLOAT_DATA = 16'hFFFF;

    function automatic int max_of(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: parameterised-width double-flop synchroniser for asynchronous
// inputs (e.g. IOCHRDY from an ISA card). Each bit is synchronised
// independently; multi-bit use is only safe for unrelated or gray-coded bits.
// Ports:
//   clk   : destination clock
//   reset : asynchronous active-low reset, flops go to RESET_VAL
//   d     : asynchronous input
//   q     : synchronised output, two clk cycles of latency
module sync_2ff #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/isa_io_cycle_master.sv
// isa_io_cycle_master: runs one complete ISA I/O read or write cycle per HPS
// request: address/AEN setup, IOW#/IOR# strobe, IOCHRDY wait-states, hold,
// then a one-cycle response carrying read data.
//
// Build option: define ISA_RDY_TIMEOUT_EN to abort a cycle after RDY_TIMEOUT
// wait-state cycles; the response then returns ISA_FLOAT_DATA with
// rsp_timeout=1. Without it a card holding IOCHRDY low stalls forever.
//
// Ports:
//   clk, reset           : clock, asynchronous active-low reset
//   req_valid/req_ready  : request handshake (ready only while idle)
//   req_write/addr/wdata : request fields, latched on accept
//   rsp_valid            : one-cycle pulse when the ISA cycle is finished
//   rsp_rdata            : read data (held across writes)
//   rsp_timeout          : cycle was aborted by the wait-state timeout
//   isa_addr, isa_aen    : address and address enable (1 = not an I/O cycle)
//   isa_iow_n, isa_ior_n : active-low I/O strobes
//   isa_data_out/oe      : write data and bus drive enable
//   isa_data_in          : read data from the bus
//   isa_iochrdy          : asynchronous card ready (0 = insert wait-states)
//
// All ISA-side outputs are registered from the next state so the pins never
// see decode glitches; an asynchronous reset forces them inactive at once.
module isa_io_cycle_master
    import isa_defs::*;
#(
    parameter int SETUP_CYCLES  = DEF_SETUP_CYCLES,
    parameter int STROBE_CYCLES = DEF_STROBE_CYCLES,
    parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
    parameter int RDY_TIMEOUT   = DEF_RDY_TIMEOUT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        rsp_timeout,
    output logic [15:0] isa_addr,
    output logic        isa_aen,
    output logic        isa_iow_n,
    output logic        isa_ior_n,
    output logic [15:0] isa_data_out,
    output logic        isa_data_oe,
    input  logic [15:0] isa_data_in,
    input  logic        isa_iochrdy
);

    localparam int MAX_CYC = max_of(max_of(SETUP_CYCLES, STROBE_CYCLES),
                                    max_of(HOLD_CYCLES, RDY_TIMEOUT));
    localparam int CW      = $clog2(MAX_CYC) + 1;

    // Counter reload values: each phase lasts (load + 1) cycles.
    localparam logic [CW-1:0] SETUP_LOAD   = CW'(SETUP_CYCLES - 1);
    localparam logic [CW-1:0] STROBE_LOAD  = CW'(STROBE_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LOAD    = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] TIMEOUT_LOAD = CW'(RDY_TIMEOUT - 1);

    isa_state_e    state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic          wr_q, wr_nx;
    logic          rdy_s;
    logic          accept;
    logic          capture;
    logic          bus_active_nx;
    logic          strobe_nx;
`ifdef ISA_RDY_TIMEOUT_EN
    logic          timeout_hit;
    logic          to_flag;
    logic          rsp_to_q;
`endif

    sync_2ff #(.WIDTH(1), .RESET_VAL(1'b0)) u_rdy_sync (
        .clk   (clk),
        .reset (reset),
        .d     (isa_iochrdy),
        .q     (rdy_s)
    );

    // req_ready is low for the first cycle after reset, so gate on it too.
    assign accept = (state == ST_IDLE) && req_ready && req_valid;
    assign wr_nx  = accept ? req_write : wr_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = (cnt != '0) ? cnt - 1'b1 : cnt;
        capture  = 1'b0;
`ifdef ISA_RDY_TIMEOUT_EN
        timeout_hit = 1'b0;
`endif
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_nx = ST_SETUP;
                    cnt_nx   = SETUP_LOAD;
                end
            end
            ST_SETUP: begin
                if (cnt == '0) begin
                    state_nx = ST_STROBE;
                    cnt_nx   = STROBE_LOAD;
                end
            end
            ST_STROBE: begin
                if (cnt == '0) begin
                    if (rdy_s) begin
                        state_nx = ST_HOLD;
                        cnt_nx   = HOLD_LOAD;
                        capture  = 1'b1;
                    end else begin
                        state_nx = ST_WAIT_RDY;
                        cnt_nx   = TIMEOUT_LOAD;
                    end
                end
            end
            ST_WAIT_RDY: begin
                // Ready wins over a timeout expiring in the same cycle.
                if (rdy_s) begin
                    state_nx = ST_HOLD;
                    cnt_nx   = HOLD_LOAD;
                    capture  = 1'b1;
                end
`ifdef ISA_RDY_TIMEOUT_EN
                else if (cnt == '0) begin
                    state_nx    = ST_HOLD;
                    cnt_nx      = HOLD_LOAD;
                    timeout_hit = 1'b1;
                end
`endif
            end
            ST_HOLD: begin
                if (cnt == '0) state_nx = ST_RESP;
            end
            ST_RESP: state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    assign bus_active_nx = (state_nx == ST_SETUP) || (state_nx == ST_STROBE) ||
                           (state_nx == ST_WAIT_RDY) || (state_nx == ST_HOLD);
    assign strobe_nx     = (state_nx == ST_STROBE) || (state_nx == ST_WAIT_RDY);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_q         <= 1'b0;
            req_ready    <= 1'b0;
            rsp_valid    <= 1'b0;
            rsp_rdata    <= '0;
            isa_addr     <= '0;
            isa_aen      <= 1'b1;
            isa_iow_n    <= 1'b1;
            isa_ior_n    <= 1'b1;
            isa_data_out <= '0;
            isa_data_oe  <= 1'b0;
        end else begin
            req_ready   <= (state_nx == ST_IDLE);
            rsp_valid   <= (state_nx == ST_RESP);
            isa_aen     <= !bus_active_nx;
            isa_iow_n   <= !(strobe_nx && wr_nx);
            isa_ior_n   <= !(strobe_nx && !wr_nx);
            isa_data_oe <= bus_active_nx && wr_nx;
            if (accept) begin
                wr_q     <= req_write;
                isa_addr <= req_addr;
                if (req_write) isa_data_out <= req_wdata;
            end
            // Sample on the last strobe-low cycle, i.e. the edge into HOLD.
            if (capture && !wr_q) rsp_rdata <= isa_data_in;
`ifdef ISA_RDY_TIMEOUT_EN
            if (timeout_hit) rsp_rdata <= ISA_FLOAT_DATA;
`endif
        end
    end

`ifdef ISA_RDY_TIMEOUT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            to_flag  <= 1'b0;
            rsp_to_q <= 1'b0;
        end else begin
            if (accept)           to_flag <= 1'b0;
            else if (timeout_hit) to_flag <= 1'b1;
            rsp_to_q <= (state_nx == ST_RESP) && to_flag;
        end
    end
    assign rsp_timeout = rsp_to_q;
`else
    assign rsp_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_isa_io_cycle_master.sv
// Bench for isa_io_cycle_master with default timing. The reference model
// derives every cycle's expected pin state from the cycle phase lengths and
// the cycle at which IOCHRDY goes high (two-flop synchroniser latency).
module tb_isa_io_cycle_master;

    localparam int S  = 2;
    localparam int T  = 6;
    localparam int H  = 2;
    localparam int TO = 256;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [15:0] req_addr = '0;
    logic [15:0] req_wdata = '0;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        rsp_timeout;
    logic [15:0] isa_addr;
    logic        isa_aen;
    logic        isa_iow_n;
    logic        isa_ior_n;
    logic [15:0] isa_data_out;
    logic        isa_data_oe;
    logic [15:0] isa_data_in = '0;
    logic        isa_iochrdy = 1'b1;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [15:0] last_rdata = '0;

    always #5 clk = ~clk;

    isa_io_cycle_master dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_timeout  (rsp_timeout),
        .isa_addr     (isa_addr),
        .isa_aen      (isa_aen),
        .isa_iow_n    (isa_iow_n),
        .isa_ior_n    (isa_ior_n),
        .isa_data_out (isa_data_out),
        .isa_data_oe  (isa_data_oe),
        .isa_data_in  (isa_data_in),
        .isa_iochrdy  (isa_iochrdy)
    );

    // One full I/O cycle. IOCHRDY is low until cycle r_cyc (counted from the
    // accept edge) and high from then on; r_cyc<=0 means always ready.
    // When vary=1 the bus data changes every cycle so the capture cycle shows.
    task automatic do_txn(input logic wr, input logic [15:0] addr,
                          input logic [15:0] wdata, input logic [15:0] din,
                          input bit vary, input int r_cyc, output int rsp_seen);
        int          last_low;
        int          rsp_k;
        bit          to;
        bit          got;
        logic        e_strb, e_act;
        logic [15:0] exp_rd;

        rsp_seen = -1;
        // Synchronised ready is seen two cycles after the pin.
        last_low = (r_cyc + 2 > S + T) ? r_cyc + 2 : S + T;
        to = 1'b0;
`ifdef ISA_RDY_TIMEOUT_EN
        if (last_low > S + T + TO) begin
            last_low = S + T + TO;
            to = 1'b1;
        end
`endif
        rsp_k = last_low + H + 1;
        if (to)       exp_rd = 16'hFFFF;
        else if (!wr) exp_rd = vary ? (din ^ 16'(last_low)) : din;
        else          exp_rd = last_rdata;

        @(posedge clk); #1;
        req_valid   = 1'b0;
        isa_iochrdy = (r_cyc <= 0);
        isa_data_in = din;
        repeat (3) @(posedge clk);
        #1;
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wdata;
        got = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (req_ready === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!got) begin
            n_fail++;
            $display("FAIL accept: req_ready=%b, required 1 within 10 cycles", req_ready);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);   // accept edge

        for (int k = 1; k <= rsp_k + 1; k++) begin
            #1;
            isa_iochrdy = (k >= r_cyc);
            isa_data_in = vary ? (din ^ 16'(k)) : din;
            // Junk requests while busy must be ignored.
            if (k < rsp_k) begin
                req_valid = 1'($urandom_range(0, 1));
                req_write = 1'($urandom);
                req_addr  = 16'($urandom);
                req_wdata = 16'($urandom);
            end else begin
                req_valid = 1'b0;
            end
            @(negedge clk);
            e_strb = (k >= S + 1) && (k <= last_low);
            e_act  = (k <= last_low + H);
            if (rsp_valid === 1'b1 && rsp_seen < 0) rsp_seen = k;

            n_checks++;
            if (isa_aen !== !e_act) begin
                n_fail++;
                $display("FAIL aen k=%0d: got %b required %b", k, isa_aen, !e_act);
            end
            n_checks++;
            if (isa_iow_n !== !(e_strb && wr)) begin
                n_fail++;
                $display("FAIL iow_n k=%0d: got %b required %b", k, isa_iow_n, !(e_strb && wr));
            end
            n_checks++;
            if (isa_ior_n !== !(e_strb && !wr)) begin
                n_fail++;
                $display("FAIL ior_n k=%0d: got %b required %b", k, isa_ior_n, !(e_strb && !wr));
            end
            n_checks++;
            if (isa_data_oe !== (e_act && wr)) begin
                n_fail++;
                $display("FAIL data_oe k=%0d: got %b required %b", k, isa_data_oe, e_act && wr);
            end
            n_checks++;
            if (isa_addr !== addr) begin
                n_fail++;
                $display("FAIL addr k=%0d: got %h required %h", k, isa_addr, addr);
            end
            if (wr) begin
                n_checks++;
                if (isa_data_out !== wdata) begin
                    n_fail++;
                    $display("FAIL data_out k=%0d: got %h required %h", k, isa_data_out, wdata);
                end
            end
            n_checks++;
            if (rsp_valid !== (k == rsp_k)) begin
                n_fail++;
                $display("FAIL rsp_valid k=%0d: got %b required %b", k, rsp_valid, k == rsp_k);
            end
            n_checks++;
            if (req_ready !== (k == rsp_k + 1)) begin
                n_fail++;
                $display("FAIL req_ready k=%0d: got %b required %b", k, req_ready, k == rsp_k + 1);
            end
            n_checks++;
            if (rsp_timeout !== ((k == rsp_k) && to)) begin
                n_fail++;
                $display("FAIL rsp_timeout k=%0d: got %b required %b", k, rsp_timeout, (k == rsp_k) && to);
            end
            if (k == rsp_k) begin
                n_checks++;
                if (rsp_rdata !== exp_rd) begin
                    n_fail++;
                    $display("FAIL rsp_rdata: got %h required %h", rsp_rdata, exp_rd);
                end
            end
            @(posedge clk);
        end
        last_rdata = exp_rd;
    endtask

    task automatic test_reset();
        reset     = 1'b0;
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 16'h1234;
        req_wdata = 16'h5678;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({req_ready, rsp_valid, rsp_timeout, isa_aen, isa_iow_n, isa_ior_n, isa_data_oe} !== 7'b0001110) begin
            n_fail++;
            $display("FAIL reset_ctl: got %b required 0001110",
                     {req_ready, rsp_valid, rsp_timeout, isa_aen, isa_iow_n, isa_ior_n, isa_data_oe});
        end
        n_checks++;
        if ({rsp_rdata, isa_addr, isa_data_out} !== 48'h0) begin
            n_fail++;
            $display("FAIL reset_data: got %h required 0", {rsp_rdata, isa_addr, isa_data_out});
        end
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_after_reset: got %b required 1", req_ready);
        end
        n_checks++;
        if ({isa_aen, isa_iow_n, isa_ior_n} !== 3'b111) begin
            n_fail++;
            $display("FAIL idle_after_reset: got %b required 111", {isa_aen, isa_iow_n, isa_ior_n});
        end
        last_rdata = '0;
    endtask

    task automatic test_write();
        int seen;
        do_txn(1'b1, 16'h0220, 16'h00A5, 16'h0000, 1'b0, 0, seen);
        n_checks++;
        if (seen !== 11) begin
            n_fail++;
            $display("FAIL write_latency: got %0d required 11", seen);
        end
    endtask

    task automatic test_read();
        int seen;
        do_txn(1'b0, 16'h022A, 16'h0000, 16'h00AA, 1'b0, 0, seen);
        n_checks++;
        if (seen !== 11) begin
            n_fail++;
            $display("FAIL read_latency: got %0d required 11", seen);
        end
    endtask

    task automatic test_wait_states();
        int seen;
        do_txn(1'b0, 16'h0300, 16'h0000, 16'h5A00, 1'b1, 12, seen);
        n_checks++;
        if (seen !== 17) begin
            n_fail++;
            $display("FAIL wait_latency: got %0d required 17", seen);
        end
        do_txn(1'b1, 16'h0310, 16'hBEEF, 16'h0000, 1'b1, 40, seen);
    endtask

    task automatic test_random();
        int seen;
        for (int n = 0; n < 20; n++) begin
            do_txn(1'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
                   1'b1, int'($urandom_range(0, 20)), seen);
        end
    endtask

`ifdef ISA_RDY_TIMEOUT_EN
    task automatic test_timeout();
        int seen;
        do_txn(1'b0, 16'h0278, 16'h0000, 16'h1234, 1'b1, 100000, seen);
        n_checks++;
        if (seen !== S + T + TO + H + 1) begin
            n_fail++;
            $display("FAIL timeout_latency: got %0d required %0d", seen, S + T + TO + H + 1);
        end
        do_txn(1'b0, 16'h0279, 16'h0000, 16'h4321, 1'b1, 0, seen);
    endtask
`endif

    task automatic test_reset_mid_cycle();
        bit got;
        bit bad_rsp;
        @(posedge clk); #1;
        isa_iochrdy = 1'b1;
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 16'h0388;
        req_wdata = 16'h00C3;
        got = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (req_ready === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        @(posedge clk); #1;   // accept edge
        req_valid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);        // cycle 5: strobe low
        n_checks++;
        if (!got || isa_iow_n !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_strobe: got iow_n=%b accepted=%b required 0,1", isa_iow_n, got);
        end
        #1 reset = 1'b0;
        #1;
        n_checks++;
        if ({isa_iow_n, isa_ior_n, isa_aen, isa_data_oe, req_ready, rsp_valid} !== 6'b111000) begin
            n_fail++;
            $display("FAIL async_abort: got %b required 111000",
                     {isa_iow_n, isa_ior_n, isa_aen, isa_data_oe, req_ready, rsp_valid});
        end
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        last_rdata = '0;
        bad_rsp = 1'b0;
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_after_abort: got %b required 1", req_ready);
        end
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0 || isa_iow_n !== 1'b1) bad_rsp = 1'b1;
        end
        n_checks++;
        if (bad_rsp) begin
            n_fail++;
            $display("FAIL no_rsp_after_abort: got activity required none");
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_wait_states();
        test_random();
`ifdef ISA_RDY_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_mid_cycle();
        test_write();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/isa_io_cycle_master.md
Name: isa_io_cycle_master

Overview:
Generates complete ISA I/O read/write cycles on behalf of the HPS: address setup, IOW#/IOR# strobe, IOCHRDY wait-states, hold.
- This is the initiator that produces the strobes, address and data the riser's bus buffer consumes.
- It takes one HPS request at a time (valid/ready) and returns a one-cycle response with read data.
- Sits between the HPS register bridge and the ISA pin buffers.

Parameters:
- SETUP_CYCLES, 2: clk cycles address/AEN are stable before the strobe asserts (>=1).
- STROBE_CYCLES, 6: minimum clk cycles the strobe is held low (>=1).
- HOLD_CYCLES, 2: clk cycles address/write data are held after the strobe deasserts (>=1).
- RDY_TIMEOUT, 256: maximum wait-state cycles before abort (only with ISA_RDY_TIMEOUT_EN).

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous active-low reset
- req_valid  input  1  HPS request present
- req_ready  output  1  block idle, request accepted when valid&ready
- req_write  input  1  1=I/O write, 0=I/O read
- req_addr  input  16  I/O address
- req_wdata  input  16  write data
- rsp_valid  output  1  one-cycle pulse, cycle finished
- rsp_rdata  output  16  read data, valid with rsp_valid (write: holds last value)
- rsp_timeout  output  1  valid with rsp_valid; cycle aborted
- isa_addr  output  16  address to ISA buffer
- isa_aen  output  1  address enable, 1=not an I/O cycle
- isa_iow_n  output  1  I/O write strobe, active low
- isa_ior_n  output  1  I/O read strobe, active low
- isa_data_out  output  16  write data to ISA buffer
- isa_data_oe  output  1  1=drive isa_data_out onto bus
- isa_data_in  input  16  data from ISA bus
- isa_iochrdy  input  1  asynchronous ready from card, 0=insert wait-states

Behaviour:
- Reset (async, reset=0) values: req_ready=0 during reset, then 1; rsp_valid=0; rsp_rdata=0; rsp_timeout=0; isa_addr=0; isa_aen=1; isa_iow_n=1; isa_ior_n=1; isa_data_out=0; isa_data_oe=0; state IDLE.
- Reset mid-cycle aborts immediately to the reset values. No response is issued.
- isa_iochrdy passes through a 2-flop synchroniser (rdy_s) before use.
- FSM states: IDLE, SETUP, STROBE, WAIT_RDY, HOLD, RESP.
- IDLE:
  - req_ready=1, isa_aen=1.
  - On valid&ready, latch addr, wdata and write into registers, then go to SETUP.
  - Request inputs are ignored outside IDLE.
- SETUP, SETUP_CYCLES cycles:
  - isa_addr=latched addr, isa_aen=0.
  - For writes: isa_data_oe=1 and isa_data_out=wdata from SETUP entry.
- STROBE, STROBE_CYCLES cycles:
  - isa_iow_n=0 (write) or isa_ior_n=0 (read). Never both.
  - On the last cycle: rdy_s=1 goes to HOLD, rdy_s=0 goes to WAIT_RDY.
- WAIT_RDY:
  - Strobe stays low.
  - Leaves for HOLD on the cycle after rdy_s is seen as 1.
- Read data capture: rsp_rdata <= isa_data_in on the final strobe-low cycle, i.e. the transition into HOLD.
- HOLD, HOLD_CYCLES cycles:
  - Strobes high; address, AEN=0 and write data/oe held.
  - On exit: isa_data_oe=0, isa_aen=1.
- RESP, 1 cycle: rsp_valid=1, then IDLE.
- Latency with no wait-states, counted as cycles after the accept edge:
  - Cycles 1..SETUP: SETUP.
  - Cycles SETUP+1..SETUP+STROBE: strobe low.
  - HOLD cycles follow.
  - rsp_valid in cycle SETUP+STROBE+HOLD+1 (11 with defaults).
  - Each wait-state cycle adds 1.
- Back-to-back: req_ready rises in the cycle after RESP. There is no overlap.
- Counter: one shared down-counter, width $clog2 of the max parameter plus 1. Reloaded on each state entry.

Optional Feature:
ISA_RDY_TIMEOUT_EN:
- Defined: WAIT_RDY counts cycles. After RDY_TIMEOUT cycles with rdy_s=0 it forces HOLD with the strobe deasserted.
- rsp_rdata is forced to 16'hFFFF and rsp_timeout=1 with rsp_valid.
- Undefined: WAIT_RDY waits indefinitely; rsp_timeout tied 0.

Decomposition:
- Shared package/include isa_defs holds:
  - FSM state encoding, 3 bits.
  - Default timing constants.
  - ISA_FLOAT_DATA constant, 16'hFFFF.
- One sub-module, sync_2ff: the parameterised-width double-flop synchroniser used for isa_iochrdy. It is reusable by other riser blocks.

Test Plan:
- Reset held low with req_valid=1 -> all outputs at reset values, no strobe; release -> req_ready=1 next cycle.
- Write addr=16'h0220, wdata=16'h00A5, iochrdy=1:
  - isa_aen=0 and isa_addr=0x0220 from cycle 1.
  - isa_iow_n low cycles 3-8; isa_ior_n stays 1.
  - data_oe=1 cycles 1-10; rsp_valid cycle 11, rsp_timeout=0.
- Read addr=16'h022A, isa_data_in=16'h00AA, iochrdy=1 -> isa_ior_n low cycles 3-8, rsp_rdata=16'h00AA at rsp_valid cycle 11, data_oe never 1.
- Read with iochrdy held low until cycle 12 -> strobe stays low until rdy_s is seen, then HOLD 2 cycles; rsp_valid delayed by the extra wait-states (cycle 17); data sampled on the last low cycle.
- ISA_RDY_TIMEOUT_EN, iochrdy stuck 0 -> strobe released after 256 wait-states, rsp_rdata=16'hFFFF, rsp_timeout=1; next request completes normally.
- reset asserted during STROBE -> strobe returns high asynchronously, no rsp_valid, req_ready=1 after release.
